// File: rtl/player_pkg.sv
// Shared action codes and pending-command entry for the paddle controller.
package player_pkg;

  localparam logic [2:0] ACT_IDLE = 3'd0;
  localparam logic [2:0] ACT_L_UP = 3'd1;
  localparam logic [2:0] ACT_L_DN = 3'd2;
  localparam logic [2:0] ACT_R_UP = 3'd3;
  localparam logic [2:0] ACT_R_DN = 3'd4;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef struct packed {
    logic valid;
    logic dir;
  } pend_t;

endpackage

// File: rtl/action_sync_filter.sv
// Two-flop synchroniser plus stability filter for the player action code;
// emits the last accepted code and one-cycle accept/error pulses.
module action_sync_filter
  import player_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_i,
  output logic [2:0] code_acc_o,
  output logic       cmd_accept_o,
  output logic       cmd_err_o
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYC);

  logic [2:0]       sync1_q, code_s_q, code_acc_q;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             cmd_accept_q, cmd_err_q;
  logic             reach;

  // The counter restarts on the edge where code_s takes a new value, so the
  // accept pulse lands 2 + STABLE_CYC cycles after the input change.
  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (sync1_q != code_s_q)
      stab_cnt_d = '0;
    else if (stab_cnt_q != CNT_SAT)
      stab_cnt_d = stab_cnt_q + 1'b1;
    reach = (stab_cnt_d == CNT_SAT) && (stab_cnt_q != CNT_SAT) &&
            (code_s_q != code_acc_q);
  end

  // NOTE: reset is sampled on the clock edge only; all state uses <= so every
  // flop sees the pre-edge values of its neighbours (the synchroniser relies on it).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= ACT_IDLE;
      code_s_q     <= ACT_IDLE;
      code_acc_q   <= ACT_IDLE;
      stab_cnt_q   <= '0;
      cmd_accept_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      sync1_q      <= code_i;
      code_s_q     <= sync1_q;
      stab_cnt_q   <= stab_cnt_d;
      cmd_accept_q <= reach && (code_s_q >= ACT_L_UP) && (code_s_q <= ACT_R_DN);
      cmd_err_q    <= reach && (code_s_q > ACT_R_DN);
      if (reach)
        code_acc_q <= code_s_q;
    end
  end

  assign code_acc_o   = code_acc_q;
  assign cmd_accept_o = cmd_accept_q;
  assign cmd_err_o    = cmd_err_q;

endmodule

// File: rtl/paddle_move_ctrl.sv
// Paddle position controller: frame counter, per-paddle pending command and
// clamped update. Define PADDLE_ACCEL_EN to enable held-direction acceleration.
module paddle_move_ctrl
  import player_pkg::*;
#(
  parameter int FRAME_DIV  = 833333,
  parameter int STABLE_CYC = 4,
  parameter int Y_W        = 10,
  parameter int Y_MAX      = 400,
  parameter int Y_INIT     = 200,
  parameter int STEP       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     player_M,
  output logic [Y_W-1:0] left_y,
  output logic [Y_W-1:0] right_y,
  output logic           frame_tick,
  output logic           cmd_accept,
  output logic           cmd_err
);

  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [2:0]      code_acc;
  logic [FC_W-1:0] frame_cnt_q;
  pend_t           pend_q [2];
  pend_t           pend_d [2];
  pend_t           pend_new [2];
  pend_t           pend_eff [2];
  logic [Y_W-1:0]  y_q [2];
  logic [Y_W-1:0]  y_d [2];
  logic [Y_W:0]    step [2];
`ifdef PADDLE_ACCEL_EN
  logic [1:0]      hold_q [2];
  logic [1:0]      hold_d [2];
  logic            last_app_q [2];
  logic            last_app_d [2];
  logic            last_dir_q [2];
  logic            last_dir_d [2];
`endif

  action_sync_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_i       (player_M),
    .code_acc_o   (code_acc),
    .cmd_accept_o (cmd_accept),
    .cmd_err_o    (cmd_err)
  );

  assign frame_tick = (frame_cnt_q == FC_W'(FRAME_DIV - 1));

  // Signed Y_W+1 arithmetic so an up move below zero is seen as negative.
  function automatic logic [Y_W-1:0] move_clamp(input logic [Y_W-1:0] y,
                                                input logic dir,
                                                input logic [Y_W:0] s);
    logic signed [Y_W:0] sum;
    sum = (dir == DIR_DN) ? $signed({1'b0, y}) + $signed(s)
                          : $signed({1'b0, y}) - $signed(s);
    if (sum < 0)
      move_clamp = '0;
    else if (sum > $signed((Y_W+1)'(Y_MAX)))
      move_clamp = Y_W'(Y_MAX);
    else
      move_clamp = sum[Y_W-1:0];
  endfunction

  always_comb begin
    pend_new[0] = '{valid: cmd_accept && (code_acc == ACT_L_UP || code_acc == ACT_L_DN),
                    dir:   (code_acc == ACT_L_DN)};
    pend_new[1] = '{valid: cmd_accept && (code_acc == ACT_R_UP || code_acc == ACT_R_DN),
                    dir:   (code_acc == ACT_R_DN)};
    for (int i = 0; i < 2; i++) begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      pend_eff[i] = pend_new[i].valid ? pend_new[i] : pend_q[i];
      pend_d[i]   = frame_tick ? '0 : pend_eff[i];
      y_d[i]      = y_q[i];
      step[i]     = (Y_W+1)'(STEP);
`ifdef PADDLE_ACCEL_EN
      hold_d[i]     = hold_q[i];
      last_app_d[i] = last_app_q[i];
      last_dir_d[i] = last_dir_q[i];
      if (frame_tick) begin
        if (pend_eff[i].valid) begin
          if (last_app_q[i] && (last_dir_q[i] == pend_eff[i].dir))
            hold_d[i] = (hold_q[i] == 2'd2) ? 2'd2 : hold_q[i] + 2'd1;
          else
            hold_d[i] = 2'd0;
          last_app_d[i] = 1'b1;
          last_dir_d[i] = pend_eff[i].dir;
        end else begin
          hold_d[i]     = 2'd0;
          last_app_d[i] = 1'b0;
        end
      end
      step[i] = (Y_W+1)'(STEP) << hold_d[i];
`endif
      if (frame_tick && pend_eff[i].valid)
        y_d[i] = move_clamp(y_q[i], pend_eff[i].dir, step[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      for (int i = 0; i < 2; i++) begin
        pend_q[i] <= '0;
        y_q[i]    <= Y_W'(Y_INIT);
`ifdef PADDLE_ACCEL_EN
        hold_q[i]     <= 2'd0;
        last_app_q[i] <= 1'b0;
        last_dir_q[i] <= DIR_UP;
`endif
      end
    end else begin
      frame_cnt_q <= frame_tick ? '0 : frame_cnt_q + 1'b1;
      for (int i = 0; i < 2; i++) begin
        pend_q[i] <= pend_d[i];
        y_q[i]    <= y_d[i];
`ifdef PADDLE_ACCEL_EN
        hold_q[i]     <= hold_d[i];
        last_app_q[i] <= last_app_d[i];
        last_dir_q[i] <= last_dir_d[i];
`endif
      end
    end
  end

  assign left_y  = y_q[0];
  assign right_y = y_q[1];

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Scoreboard bench for paddle_move_ctrl: frame-aligned directed stimulus pushes
// expected pulses and positions; a monitor pops and compares them.
module tb_paddle_move_ctrl;

  localparam int FRAME_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] player_M = 3'd0;
  logic [9:0] left_y, right_y;
  logic       frame_tick, cmd_accept, cmd_err;

  paddle_move_ctrl #(.FRAME_DIV(FRAME_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .player_M   (player_M),
    .left_y     (left_y),
    .right_y    (right_y),
    .frame_tick (frame_tick),
    .cmd_accept (cmd_accept),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = -1;
  bit tick_d = 1'b0;

  int ev_q[$];      // 1 = accept pulse, 2 = error pulse
  int exp_l_q[$];
  int exp_r_q[$];

  int ml = 200, mr = 200, hl = 0, hr = 0;
  bit al = 0, ar = 0, dl = 0, dr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary_and_finish();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Paddle reference: one frame tick with optional pending command.
  task automatic model_pad(inout int y, inout int hold, inout bit app, inout bit dprev,
                           input bit v, input bit d);
    int s;
    s = 4;
`ifdef PADDLE_ACCEL_EN
    if (v) begin
      hold  = (app && dprev == d) ? ((hold < 2) ? hold + 1 : 2) : 0;
      app   = 1'b1;
      dprev = d;
    end else begin
      hold = 0;
      app  = 1'b0;
    end
    s = 4 << hold;
`endif
    if (v)
      y = d ? ((y + s > 400) ? 400 : y + s) : ((y - s < 0) ? 0 : y - s);
  endtask

  // Monitor: pops expectations whenever the DUT pulses or a tick has just applied.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_accept || cmd_err) begin
        if (cmd_accept) last_acc_cyc = cyc;
        if (ev_q.size() == 0)
          check("pulse_unexpected", {cmd_err, cmd_accept}, 0);
        else
          check("pulse_kind", {cmd_err, cmd_accept}, ev_q.pop_front());
      end
      if (tick_d) begin
        if (exp_l_q.size() == 0) begin
          check("tick_without_expectation", exp_l_q.size(), 1);
        end else begin
          check("left_y", left_y, exp_l_q.pop_front());
          check("right_y", right_y, exp_r_q.pop_front());
        end
      end
      tick_d = frame_tick;
    end
  end

  task automatic check_later(input string name, input bit is_left, input int exp);
    @(negedge clk);
    check(name, is_left ? int'(left_y) : int'(right_y), exp);
  endtask

  // Starts at a negedge where frame_tick is high; ends at the next such negedge.
  task automatic run_frame(input int c0, input int n0, input int c1, input int n1,
                           input int c2, input int n2, input int n_acc, input int n_err,
                           input bit lv, input bit ld, input bit rv, input bit rd);
    int w;
    for (int i = 0; i < n_acc; i++) ev_q.push_back(1);
    for (int i = 0; i < n_err; i++) ev_q.push_back(2);
    model_pad(ml, hl, al, dl, lv, ld);
    model_pad(mr, hr, ar, dr, rv, rd);
    exp_l_q.push_back(ml);
    exp_r_q.push_back(mr);
    player_M = 3'(c0); repeat (n0) @(negedge clk);
    player_M = 3'(c1); repeat (n1) @(negedge clk);
    player_M = 3'(c2); repeat (n2) @(negedge clk);
    w = 0;
    while (!frame_tick && w < 2 * FRAME_DIV) begin
      @(negedge clk);
      w++;
    end
    if (!frame_tick) begin
      check("frame_tick_timeout", frame_tick, 1);
      summary_and_finish();
    end
  endtask

  initial begin
    int n;
    int t_drive;

    // Reset for three cycles.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_left_y", left_y, 200);
    check("reset_right_y", right_y, 200);
    check("reset_frame_tick", frame_tick, 0);
    check("reset_cmd_accept", cmd_accept, 0);
    check("reset_cmd_err", cmd_err, 0);

    exp_l_q.push_back(200);
    exp_r_q.push_back(200);
    rst_n = 1'b1;
    n = 1;
    while (!frame_tick && n < 3 * FRAME_DIV) begin
      @(negedge clk);
      n++;
    end
    check("first_tick_cycle", n, FRAME_DIV);
    if (!frame_tick) summary_and_finish();

    // Single left-up command: accept 2+4 cycles after the change.
    t_drive = cyc;
    run_frame(1, 7, 0, 9, 0, 0, 1, 0, 1, 0, 0, 0);
    check("accept_latency", last_acc_cyc - t_drive, 6);
    fork check_later("single_left_196", 1'b1, 196); join_none

    // Glitch of code 3 held only 3 cycles.
    run_frame(3, 3, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0);
    fork check_later("glitch_right_200", 1'b0, 200); join_none

    // Two left commands in one frame: the later (down) wins.
    run_frame(1, 5, 2, 5, 0, 6, 2, 0, 1, 1, 0, 0);
    fork check_later("conflict_left_200", 1'b1, 200); join_none

    // Invalid code held a whole frame: one error pulse, then idle.
    run_frame(6, 16, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_frame(0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Clamp at Y_MAX with repeated left-down.
    for (int k = 0; k < 60; k++)
      run_frame(2, 7, 0, 9, 0, 0, 1, 0, 1, 1, 0, 0);
    fork check_later("clamp_left_max", 1'b1, 400); join_none

    // Clamp at 0 with repeated left-up.
    for (int k = 0; k < 110; k++)
      run_frame(1, 7, 0, 9, 0, 0, 1, 0, 1, 0, 0, 0);
    fork check_later("clamp_left_zero", 1'b1, 0); join_none

    // Right-down held across four frames, then idle, then once more.
    run_frame(0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      run_frame(4, 7, 0, 9, 0, 0, 1, 0, 0, 0, 1, 1);
`ifdef PADDLE_ACCEL_EN
    fork check_later("accel_right_4frames", 1'b0, 244); join_none
`else
    fork check_later("accel_right_4frames", 1'b0, 216); join_none
`endif
    run_frame(0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_frame(4, 7, 0, 9, 0, 0, 1, 0, 0, 0, 1, 1);
`ifdef PADDLE_ACCEL_EN
    fork check_later("accel_right_after_idle", 1'b0, 248); join_none
`else
    fork check_later("accel_right_after_idle", 1'b0, 220); join_none
`endif

    repeat (3) @(negedge clk);
    check("pending_pulse_expectations", ev_q.size(), 0);
    check("pending_position_expectations", exp_l_q.size(), 0);
    summary_and_finish();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
